uart_receiver_cfg: RTL and testbench
====================================

Name: uart_receiver_cfg

Overview:
Parametrised, runtime-configurable UART receiver: 5..DATA_SIZE data bits, none/even/odd parity, 1 or 2 stop bits.
- Oversampled by an external sample_tick enable rather than by clk directly.
- Completed frames are buffered in an internal first-word-fall-through FIFO.
- Exposes a sticky-error status register with explicit clear.
- Sits between the baud generator and the bus interface, next to the UART transmitter.

Parameters:
DATA_SIZE, 8, maximum data bits per frame (5..9); bus_data width
SIZE_FIFO, 8, receive FIFO depth in frames, power of 2, >=2
OVERSAMPLE, 16, sample_tick pulses per bit time, even, >=8

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
sample_tick  input  1  one-cycle enable, OVERSAMPLE pulses per bit time
serial_data_in  input  1  asynchronous serial line, idle high
cfg_data_bits  input  4  data bits per frame, 5..DATA_SIZE; out-of-range values clamp to DATA_SIZE
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none
cfg_stop_bits  input  1  0 = one stop bit, 1 = two stop bits
read_data  input  1  pop FIFO head on this clk edge
clr_status  input  1  clear sticky status bits
bus_data  output  DATA_SIZE  FIFO head, zero-extended above cfg_data_bits
rx_valid  output  1  FIFO not empty
fifo_count  output  $clog2(SIZE_FIFO)+1  frames held
status_register  output  8  {rx_busy, overflow_error, stop_error, break_error, parity_error, empty, full, underflow_error}

Behaviour:
- Reset: FSM IDLE; FIFO cleared; bus_data 0; rx_valid 0; fifo_count 0; status_register 8'h04.
- Reset mid-frame discards the partial frame.
- serial_data_in passes through a 2-flop synchroniser (reset value 1). All sampling uses the synchronised value.
- The sample counter advances only on sample_tick. Bit decision point is mid = OVERSAMPLE/2-1 ticks in START, then OVERSAMPLE-1 ticks per subsequent bit.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
  - IDLE: synchronised line low -> START, counter cleared. cfg_* latched here; changes mid-frame are ignored.
  - START: at mid, line low -> DATA; line high -> IDLE (glitch: no write, no error).
  - DATA: shift in LSB first. After cfg_data_bits bits -> PARITY if parity enabled, else STOP1.
  - PARITY: sample, compare against XOR of the data bits (even) or its inverse (odd).
  - STOP1: sample, then -> STOP2 if cfg_stop_bits=1, else frame end. STOP2: sample, frame end.
  - Frame end, break detected (all data bits 0, parity bit 0 if enabled, STOP1 sample 0): set break_error, no FIFO write, -> BREAK_WAIT. BREAK_WAIT: synchronised line high -> IDLE.
  - Frame end, otherwise: write frame to FIFO on the clk edge after the final stop decision, -> IDLE. rx_valid is high the following cycle.
- Parity or stop error: frame still written; parity_error / stop_error set.
- FIFO: bus_data always shows the head.
  - read_data with FIFO non-empty pops on the edge.
  - read_data with FIFO empty: no pointer change; set underflow_error. This applies even if a write occurs in the same cycle.
- Write while full:
  - With read_data in the same cycle: both the pop and the write happen; count unchanged; no overflow.
  - Without read_data: frame dropped; set overflow_error.
- Pointers wrap modulo SIZE_FIFO. fifo_count ranges 0..SIZE_FIFO. full = (count==SIZE_FIFO); empty = (count==0).
- Sticky bits [6:3] and [0] hold until clr_status. If a set and clr_status coincide, the set wins.
- rx_busy = FSM not in IDLE.

Optional Feature:
Macro: UART_RX_MAJORITY_EN
- Defined: every decision (start validation, data, parity, stop) is the 2-of-3 majority of samples taken at ticks mid-1, mid, mid+1. The decision is taken at mid+1 and the following bit's count is unchanged.
- Undefined: a single sample at mid; the majority logic is absent from the netlist.

Test Plan:
All scenarios use DATA_SIZE=8, SIZE_FIFO=8, OVERSAMPLE=16, sample_tick=1 every cycle.
- 8N1 frame 0xA5 -> rx_valid=1, bus_data=0xA5, fifo_count=1, status=8'h00; after read_data -> status=8'h04, bus_data unchanged content irrelevant, rx_valid=0.
- 7E1, cfg_data_bits=7, 0x41 sent with wrong parity bit -> bus_data=0x41, status[3]=1; clr_status pulse -> status[3]=0.
- 9 back-to-back 8N1 frames 0x01..0x09, no reads -> fifo_count=8, full=1, status[6]=1, 0x09 dropped; 8 reads return 0x01..0x08 in order, then empty=1.
- Line held low 12 bit times -> status[4]=1, no write, rx_busy=1 until line high; a following 0x55 is received correctly.
- Low pulse of 4 ticks on idle line -> FSM returns to IDLE, no write, status unchanged.
- 8N2 with second stop bit low, data 0x3C -> 0x3C written, status[5]=1; read_data on empty FIFO -> status[0]=1.

Source files
------------

// File: rtl/uart_receiver_cfg.sv
// Runtime-configurable UART receiver (5..DATA_SIZE bits, N/E/O parity, 1/2 stop) feeding a FWFT FIFO.
// Optional build macro UART_RX_MAJORITY_EN: each bit is decided by a 2-of-3 vote around the bit centre.
module uart_receiver_cfg #(
  parameter int DATA_SIZE  = 8,
  parameter int SIZE_FIFO  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_tick,
  input  logic                       serial_data_in,
  input  logic [3:0]                 cfg_data_bits,
  input  logic [1:0]                 cfg_parity,
  input  logic                       cfg_stop_bits,
  input  logic                       read_data,
  input  logic                       clr_status,
  output logic [DATA_SIZE-1:0]       bus_data,
  output logic                       rx_valid,
  output logic [$clog2(SIZE_FIFO):0] fifo_count,
  output logic [7:0]                 status_register
);
  localparam int SW    = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_SIZE);
  localparam int PTR_W = $clog2(SIZE_FIFO);
  localparam logic [SW-1:0]  MID      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]  LAST     = SW'(OVERSAMPLE - 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(SIZE_FIFO);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT} state_t;

  state_t state_q, state_d;

  // Line synchroniser
  logic rx_p0, rx_p1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= serial_data_in;
      rx_p1 <= rx_p0;
    end
  end

  // Frame format is captured while idle so mid-frame changes cannot corrupt a frame
  logic [3:0] bits_q;
  logic       par_en_q, par_odd_q, stop2_q;
  logic       cfg_bits_ok;
  assign cfg_bits_ok = (cfg_data_bits >= 4'd5) && (cfg_data_bits <= 4'(DATA_SIZE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bits_q    <= 4'(DATA_SIZE);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      bits_q    <= cfg_bits_ok ? cfg_data_bits : 4'(DATA_SIZE);
      par_en_q  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_odd_q <= (cfg_parity == 2'b10);
      stop2_q   <= cfg_stop_bits;
    end
  end

  // Oversample counter: restarts at the start-bit centre, then wraps once per bit time
  logic [SW-1:0] cnt_q, mid_sel;
  logic          at_mid;
  assign mid_sel = (state_q == START) ? MID : LAST;
  assign at_mid  = sample_tick && (cnt_q == mid_sel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt_q <= '0;
    else if (state_q == IDLE)    cnt_q <= '0;
    else if (sample_tick)        cnt_q <= at_mid ? '0 : cnt_q + SW'(1);
  end

  logic decide, bit_val;
`ifdef UART_RX_MAJORITY_EN
  // Vote is resolved one tick after the centre; the counter already wrapped, so bit timing is kept
  logic s_m1, s_m0, pend_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             pend_q <= 1'b0;
    else if (state_q == IDLE) pend_q <= 1'b0;
    else if (sample_tick)     pend_q <= at_mid;
  end

  always_ff @(posedge clk) begin
    if (sample_tick && (cnt_q == mid_sel - SW'(1))) s_m1 <= rx_p1;
    if (at_mid) s_m0 <= rx_p1;
  end

  assign decide  = sample_tick && pend_q;
  assign bit_val = (s_m1 & s_m0) | (s_m1 & rx_p1) | (s_m0 & rx_p1);
`else
  assign decide  = at_mid;
  assign bit_val = rx_p1;
`endif

  logic [DATA_SIZE-1:0] data_sh, frame_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 par_q, stop1_q, perr_q, serr_q, done_q;
  logic                 last_bit, frame_end, stop1_val, brk_det;

  assign last_bit  = (int'(bit_idx_q) + 1) == int'(bits_q);
  assign frame_end = decide && (((state_q == STOP1) && !stop2_q) || (state_q == STOP2));
  assign stop1_val = (state_q == STOP1) ? bit_val : stop1_q;
  assign brk_det   = (data_sh == '0) && !(par_en_q && par_q) && !stop1_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               bit_idx_q <= '0;
    else if (state_q == IDLE)                   bit_idx_q <= '0;
    else if (decide && (state_q == DATA))       bit_idx_q <= bit_idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE)                        data_sh <= '0;
    else if (decide && (state_q == DATA))       data_sh[bit_idx_q] <= bit_val;
    if (decide && (state_q == PARITY))          par_q   <= bit_val;
    if (decide && (state_q == STOP1))           stop1_q <= bit_val;
    if (frame_end) begin
      frame_q <= data_sh;
      perr_q  <= par_en_q && (par_q != (^data_sh ^ par_odd_q));
      serr_q  <= !stop1_val || ((state_q == STOP2) && !bit_val);
    end
  end

  // Completed frame is presented to the FIFO one edge after the final stop decision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= frame_end && !brk_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (!rx_p1) state_d = START;
      START:      if (decide) state_d = bit_val ? IDLE : DATA;
      DATA:       if (decide && last_bit) state_d = par_en_q ? PARITY : STOP1;
      PARITY:     if (decide) state_d = STOP1;
      STOP1:      if (decide) state_d = stop2_q ? STOP2 : (brk_det ? BREAK_WAIT : IDLE);
      STOP2:      if (decide) state_d = brk_det ? BREAK_WAIT : IDLE;
      BREAK_WAIT: if (rx_p1) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Receive FIFO
  logic [DATA_SIZE-1:0] mem [SIZE_FIFO];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q;
  logic                 fifo_empty, fifo_full, do_rd, do_wr;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign do_rd      = read_data && !fifo_empty;
  assign do_wr      = done_q && (!fifo_full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= frame_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W + 1)'(do_wr) - (PTR_W + 1)'(do_rd);
    end
  end

  // Sticky status: a new event in the clearing cycle survives the clear
  logic ovf_q, serr_st_q, brk_q, perr_st_q, unf_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q     <= 1'b0;
      serr_st_q <= 1'b0;
      brk_q     <= 1'b0;
      perr_st_q <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      ovf_q     <= (done_q && fifo_full && !do_rd) || (ovf_q && !clr_status);
      serr_st_q <= (done_q && serr_q) || (serr_st_q && !clr_status);
      brk_q     <= (frame_end && brk_det) || (brk_q && !clr_status);
      perr_st_q <= (done_q && perr_q) || (perr_st_q && !clr_status);
      unf_q     <= (read_data && fifo_empty) || (unf_q && !clr_status);
    end
  end

  assign bus_data        = fifo_empty ? '0 : mem[rd_ptr_q];
  assign rx_valid        = !fifo_empty;
  assign fifo_count      = count_q;
  assign status_register = {state_q != IDLE, ovf_q, serr_st_q, brk_q, perr_st_q,
                            fifo_empty, fifo_full, unf_q};
endmodule

// File: tb/tb_uart_receiver_cfg.sv
// Directed bench for uart_receiver_cfg: DATA_SIZE=8, SIZE_FIFO=8, OVERSAMPLE=16, tick every cycle.
module tb_uart_receiver_cfg;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sample_tick = 1'b1;
  logic       serial_data_in = 1'b1;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop_bits = 1'b0;
  logic       read_data = 1'b0;
  logic       clr_status = 1'b0;
  logic [7:0] bus_data;
  logic       rx_valid;
  logic [3:0] fifo_count;
  logic [7:0] status_register;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_receiver_cfg #(.DATA_SIZE(8), .SIZE_FIFO(8), .OVERSAMPLE(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sample_tick     (sample_tick),
    .serial_data_in  (serial_data_in),
    .cfg_data_bits   (cfg_data_bits),
    .cfg_parity      (cfg_parity),
    .cfg_stop_bits   (cfg_stop_bits),
    .read_data       (read_data),
    .clr_status      (clr_status),
    .bus_data        (bus_data),
    .rx_valid        (rx_valid),
    .fifo_count      (fifo_count),
    .status_register (status_register)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bit time = 16 clocks; line changes on the falling edge
  task automatic send_bit(input logic b);
    serial_data_in = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input logic par_en,
                            input logic par_bit, input logic s1, input logic two_stop,
                            input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (par_en) send_bit(par_bit);
    send_bit(s1);
    if (two_stop) send_bit(s2);
    serial_data_in = 1'b1;
  endtask

  task automatic read_pulse();
    read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_status", status_register, 8'h04);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_count", fifo_count, 4'd0);
    check("reset_bus_data", bus_data, 8'h00);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("a5_rx_valid", rx_valid, 1'b1);
    check("a5_bus_data", bus_data, 8'hA5);
    check("a5_count", fifo_count, 4'd1);
    check("a5_status", status_register, 8'h00);
    read_pulse();
    check("a5_read_status", status_register, 8'h04);
    check("a5_read_rx_valid", rx_valid, 1'b0);

    // 7E1 0x41 (two ones, correct even parity 0) sent with parity 1
    cfg_data_bits = 4'd7;
    cfg_parity    = 2'b01;
    send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("7e1_bus_data", bus_data, 8'h41);
    check("7e1_parity_err", status_register[3], 1'b1);
    check("7e1_status", status_register, 8'h08);
    clr_pulse();
    check("7e1_clr_parity", status_register[3], 1'b0);
    read_pulse();
    check("7e1_drained", status_register, 8'h04);
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'b00;
    repeat (2) @(negedge clk);

    // Nine frames without reads: ninth is dropped
    for (int k = 1; k <= 9; k++) send_frame(9'(k), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("ovf_count", fifo_count, 4'd8);
    check("ovf_full", status_register[1], 1'b1);
    check("ovf_flag", status_register[6], 1'b1);
    check("ovf_status", status_register, 8'h42);
    for (int k = 1; k <= 8; k++) begin
      check("ovf_read_order", bus_data, 8'(k));
      read_pulse();
    end
    check("ovf_empty", status_register[2], 1'b1);
    check("ovf_final_count", fifo_count, 4'd0);
    clr_pulse();
    check("ovf_cleared", status_register, 8'h04);

    // Break: line low for 12 bit times
    serial_data_in = 1'b0;
    repeat (12 * 16) @(negedge clk);
    check("brk_flag", status_register[4], 1'b1);
    check("brk_busy", status_register[7], 1'b1);
    check("brk_no_write", fifo_count, 4'd0);
    check("brk_status", status_register, 8'h94);
    serial_data_in = 1'b1;
    repeat (6) @(negedge clk);
    check("brk_released", status_register, 8'h14);
    send_frame(9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("brk_next_data", bus_data, 8'h55);
    check("brk_next_count", fifo_count, 4'd1);
    read_pulse();
    clr_pulse();
    check("brk_cleared", status_register, 8'h04);

    // Four-tick glitch on the idle line
    serial_data_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_data_in = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", status_register[7], 1'b1);
    repeat (20) @(negedge clk);
    check("glitch_status", status_register, 8'h04);
    check("glitch_count", fifo_count, 4'd0);

    // 8N2 0x3C, second stop bit low
    cfg_stop_bits = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (24) @(negedge clk);
    check("8n2_bus_data", bus_data, 8'h3C);
    check("8n2_count", fifo_count, 4'd1);
    check("8n2_status", status_register, 8'h20);
    read_pulse();
    check("8n2_pop_no_underflow", status_register, 8'h24);
    read_pulse();
    check("underflow_flag", status_register[0], 1'b1);
    check("underflow_status", status_register, 8'h25);
    clr_pulse();
    check("final_cleared", status_register, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
